// File: rtl/wb_traffic_master.sv
//==============================================================================
// Module      : wb_traffic_master
// Description : Wishbone classic master traffic generator and read checker.
//               Accepts burst commands on a valid/ready port and issues write
//               or read bursts whose beat k carries the pattern seed + k.
//               On read bursts the returned data is compared against that
//               pattern. Mismatch count, first mismatch address and abort
//               flags are reported.
//
// Ports       : sys_clk, sys_resetn    - clock, async active-low reset
//               cmd_valid/cmd_ready    - command handshake
//               cmd_we/addr/len/seed   - burst direction, start address,
//                                        beats-1, pattern seed
//               wb_*                   - Wishbone classic master port
//               busy, done             - activity and end-of-burst pulse
//               err_cnt, first_err_addr- read-check results of last burst
//               timeout_flag           - last burst aborted by ack timeout
//               bus_err_flag           - last burst aborted by wb_err_i
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_traffic_master #(
    parameter int DW          = 32,
    parameter int APP_ADDR_W  = 26,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  sys_clk,
    input  logic                  sys_resetn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [APP_ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [DW-1:0]         cmd_seed,

    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [DW/8-1:0]       wb_sel_o,
    output logic [APP_ADDR_W-1:0] wb_addr_o,
    output logic [DW-1:0]         wb_dat_o,
    input  logic [DW-1:0]         wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,

    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_cnt,
    output logic [APP_ADDR_W-1:0] first_err_addr,
    output logic                  timeout_flag,
    output logic                  bus_err_flag
);

    localparam int                  c_sel_w      = DW / 8;
    localparam int                  c_wait_w     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [APP_ADDR_W-1:0] c_beat_bytes = APP_ADDR_W'(DW / 8);
    // Clears the sub-word byte-offset bits of the start address.
    localparam logic [APP_ADDR_W-1:0] c_addr_mask  = ~(APP_ADDR_W'(DW / 8 - 1));
    localparam logic [c_wait_w-1:0] c_wait_last  = c_wait_w'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        r_beat;
    logic [c_wait_w-1:0]     r_wait;

    logic                    r_cmd_ready;
    logic                    r_cyc;
    logic                    r_stb;
    logic                    r_we;
    logic [c_sel_w-1:0]      r_sel;
    logic [APP_ADDR_W-1:0]   r_addr;
    // Holds seed + k: both the write data and the expected read data.
    logic [DW-1:0]           r_dat;
    logic                    r_busy;
    logic                    r_done;
    logic [15:0]             r_err_cnt;
    logic [APP_ADDR_W-1:0]   r_first_err_addr;
    logic                    r_timeout_flag;
    logic                    r_bus_err_flag;

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_state          <= S_IDLE;
            r_len            <= '0;
            r_beat           <= '0;
            r_wait           <= '0;
            r_cmd_ready      <= 1'b1;
            r_cyc            <= 1'b0;
            r_stb            <= 1'b0;
            r_we             <= 1'b0;
            r_sel            <= '0;
            r_addr           <= '0;
            r_dat            <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_timeout_flag   <= 1'b0;
            r_bus_err_flag   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (cmd_valid && r_cmd_ready) begin
                        r_state          <= S_BUS;
                        r_cmd_ready      <= 1'b0;
                        r_busy           <= 1'b1;
                        r_cyc            <= 1'b1;
                        r_stb            <= 1'b1;
                        r_we             <= cmd_we;
                        r_sel            <= '1;
                        r_addr           <= cmd_addr & c_addr_mask;
                        r_dat            <= cmd_seed;
                        r_len            <= cmd_len;
                        r_beat           <= '0;
                        r_wait           <= '0;
                        r_err_cnt        <= '0;
                        r_first_err_addr <= '0;
                        r_timeout_flag   <= 1'b0;
                        r_bus_err_flag   <= 1'b0;
                    end
                end

                S_BUS: begin
                    // Bus error takes priority over a simultaneous ack; the
                    // errored beat is neither counted nor checked.
                    if (wb_err_i) begin
                        r_cyc          <= 1'b0;
                        r_stb          <= 1'b0;
                        r_we           <= 1'b0;
                        r_sel          <= '0;
                        r_bus_err_flag <= 1'b1;
                        r_done         <= 1'b1;
                        r_state        <= S_DONE;
                    end else if (wb_ack_i) begin
                        if (!r_we && (wb_dat_i != r_dat)) begin
                            if (r_err_cnt != 16'hFFFF) begin
                                r_err_cnt <= r_err_cnt + 16'd1;
                            end
                            // Status is cleared at accept, so a zero count
                            // means this is the first mismatch of the burst.
                            if (r_err_cnt == 16'd0) begin
                                r_first_err_addr <= r_addr;
                            end
                        end
                        r_wait <= '0;
                        if (r_beat == r_len) begin
                            r_cyc   <= 1'b0;
                            r_stb   <= 1'b0;
                            r_we    <= 1'b0;
                            r_sel   <= '0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                            r_addr <= r_addr + c_beat_bytes;
                            r_dat  <= r_dat + 1'b1;
                        end
                    end else if (r_wait == c_wait_last) begin
                        // TIMEOUT_CYC strobe cycles have now elapsed without ack.
                        r_cyc          <= 1'b0;
                        r_stb          <= 1'b0;
                        r_we           <= 1'b0;
                        r_sel          <= '0;
                        r_timeout_flag <= 1'b1;
                        r_done         <= 1'b1;
                        r_state        <= S_DONE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end

                S_DONE: begin
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_cyc       <= 1'b0;
                    r_stb       <= 1'b0;
                    r_we        <= 1'b0;
                    r_sel       <= '0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready      = r_cmd_ready;
    assign wb_cyc_o       = r_cyc;
    assign wb_stb_o       = r_stb;
    assign wb_we_o        = r_we;
    assign wb_sel_o       = r_sel;
    assign wb_addr_o      = r_addr;
    assign wb_dat_o       = r_dat;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_err_addr;
    assign timeout_flag   = r_timeout_flag;
    assign bus_err_flag   = r_bus_err_flag;

endmodule

`default_nettype wire

// File: tb/tb_wb_traffic_master.sv
//==============================================================================
// Module      : tb_wb_traffic_master
// Description : Directed self-checking bench for wb_traffic_master. Inputs
//               change just after the falling edge and outputs are sampled
//               there, half a cycle away from the active rising edge.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wb_traffic_master;

    logic        sys_clk;
    logic        sys_resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [25:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] cmd_seed;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [25:0] wb_addr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        busy;
    logic        done;
    logic [15:0] err_cnt;
    logic [25:0] first_err_addr;
    logic        timeout_flag;
    logic        bus_err_flag;

    int n_vec;
    int n_err;

    wb_traffic_master dut (
        .sys_clk        (sys_clk),
        .sys_resetn     (sys_resetn),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_we         (cmd_we),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_seed       (cmd_seed),
        .wb_cyc_o       (wb_cyc_o),
        .wb_stb_o       (wb_stb_o),
        .wb_we_o        (wb_we_o),
        .wb_sel_o       (wb_sel_o),
        .wb_addr_o      (wb_addr_o),
        .wb_dat_o       (wb_dat_o),
        .wb_dat_i       (wb_dat_i),
        .wb_ack_i       (wb_ack_i),
        .wb_err_i       (wb_err_i),
        .busy           (busy),
        .done           (done),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .timeout_flag   (timeout_flag),
        .bus_err_flag   (bus_err_flag)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one full cycle: across the rising edge to the next falling edge.
    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    // Present a command; returns at the falling edge of the first bus cycle.
    task automatic issue(input logic we, input logic [25:0] addr,
                         input logic [7:0] len, input logic [31:0] seed);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_seed  = seed;
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Four-beat read at 0x100 with one wait state per beat; beats whose bit
    // is set in corrupt get their upper half inverted.
    task automatic read4_wait1(input logic [31:0] seed, input logic [3:0] corrupt);
        for (int k = 0; k < 4; k++) begin
            wb_ack_i = 1'b0;
            chk("rd_stb", 64'(wb_stb_o), 64'd1);
            chk("rd_addr", 64'(wb_addr_o), 64'(26'h100 + 26'(4 * k)));
            tick();
            wb_ack_i = 1'b1;
            wb_dat_i = (seed + 32'(k)) ^ (corrupt[k] ? 32'hFFFF0000 : 32'h0);
            tick();
        end
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        chk("rd_done", 64'(done), 64'd1);
        chk("rd_cyc_low", 64'(wb_cyc_o), 64'd0);
    endtask

    initial begin
        int stb_cycles;
        n_vec      = 0;
        n_err      = 0;
        sys_resetn = 1'b0;
        cmd_valid  = 1'b0;
        cmd_we     = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        cmd_seed   = '0;
        wb_dat_i   = '0;
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;

        // ---------------- reset values ----------------
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_cyc", 64'(wb_cyc_o), 64'd0);
        chk("rst_stb", 64'(wb_stb_o), 64'd0);
        chk("rst_sel", 64'(wb_sel_o), 64'd0);
        chk("rst_addr", 64'(wb_addr_o), 64'd0);
        chk("rst_dat", 64'(wb_dat_o), 64'd0);
        chk("rst_busy_done", 64'({busy, done}), 64'd0);
        chk("rst_status", 64'({err_cnt, timeout_flag, bus_err_flag}), 64'd0);
        sys_resetn = 1'b1;
        tick();

        // ---------------- zero-wait write ----------------
        wb_ack_i = 1'b1;     // ack high while idle must be ignored
        tick();
        chk("idle_ack_ignored", 64'({wb_cyc_o, busy}), 64'd0);
        issue(1'b1, 26'h100, 8'd3, 32'hA5A50000);
        chk("wr_cmd_ready_low", 64'(cmd_ready), 64'd0);
        chk("wr_we_sel", 64'({wb_we_o, wb_sel_o}), 64'h1F);
        for (int k = 0; k < 4; k++) begin
            chk("wr_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'd3);
            chk("wr_addr", 64'(wb_addr_o), 64'(26'h100 + 26'(4 * k)));
            chk("wr_dat", 64'(wb_dat_o), 64'(32'hA5A50000 + 32'(k)));
            tick();
        end
        wb_ack_i = 1'b0;
        chk("wr_done", 64'(done), 64'd1);
        chk("wr_cyc_with_done", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 64'd0);
        chk("wr_ready_in_done", 64'({cmd_ready, busy}), 64'b01);
        tick();
        chk("wr_done_one_cycle", 64'(done), 64'd0);
        chk("wr_ready_back", 64'({cmd_ready, busy}), 64'b10);

        // ---------------- clean read ----------------
        issue(1'b0, 26'h100, 8'd3, 32'hA5A50000);
        chk("rd_we_low", 64'(wb_we_o), 64'd0);
        read4_wait1(32'hA5A50000, 4'b0000);
        tick();
        chk("rd_clean_err_cnt", 64'(err_cnt), 64'd0);
        chk("rd_clean_first", 64'(first_err_addr), 64'd0);
        chk("rd_clean_flags", 64'({timeout_flag, bus_err_flag}), 64'd0);
        chk("rd_clean_ready", 64'(cmd_ready), 64'd1);

        // ---------------- corrupted read (beats 1 and 2) ----------------
        issue(1'b0, 26'h100, 8'd3, 32'hA5A50000);
        read4_wait1(32'hA5A50000, 4'b0110);
        tick();
        chk("rd_bad_err_cnt", 64'(err_cnt), 64'd2);
        chk("rd_bad_first", 64'(first_err_addr), 64'h104);
        tick();
        chk("rd_bad_status_hold", 64'({err_cnt, first_err_addr}), 64'({16'd2, 26'h104}));

        // ---------------- ack timeout ----------------
        issue(1'b0, 26'h200, 8'd0, 32'h12345678);
        stb_cycles = 0;
        for (int i = 0; i < 300; i++) begin
            if (!wb_stb_o) break;
            stb_cycles++;
            tick();
        end
        chk("to_stb_cycles", 64'(stb_cycles), 64'd255);
        chk("to_done", 64'(done), 64'd1);
        chk("to_cyc", 64'(wb_cyc_o), 64'd0);
        chk("to_flags", 64'({timeout_flag, bus_err_flag}), 64'b10);
        chk("to_err_cnt_cleared", 64'(err_cnt), 64'd0);
        tick();
        chk("to_flag_sticky", 64'({timeout_flag, cmd_ready}), 64'b11);

        // ---------------- bus error on beat 2 of 8 ----------------
        issue(1'b0, 26'h300, 8'd7, 32'h0000BEEF);
        chk("be_flags_cleared", 64'({timeout_flag, bus_err_flag}), 64'd0);
        wb_ack_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wb_dat_i = 32'h0000BEEF + 32'(k);
            tick();
        end
        chk("be_addr_beat2", 64'(wb_addr_o), 64'h308);
        wb_err_i = 1'b1;
        wb_dat_i = 32'hDEADDEAD;   // bad data on the errored beat
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        chk("be_done", 64'(done), 64'd1);
        chk("be_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
        chk("be_flags", 64'({timeout_flag, bus_err_flag}), 64'b01);
        chk("be_err_cnt", 64'(err_cnt), 64'd0);
        tick();
        chk("be_sticky_idle", 64'({bus_err_flag, busy, cmd_ready}), 64'b101);

        // ---------------- address wrap (offset bits ignored) ----------------
        wb_ack_i = 1'b1;
        issue(1'b1, 26'h3FFFFFF, 8'd1, 32'hFFFFFFFF);
        chk("wrap_addr0", 64'(wb_addr_o), 64'h3FFFFFC);
        chk("wrap_dat0", 64'(wb_dat_o), 64'hFFFFFFFF);
        tick();
        chk("wrap_addr1", 64'(wb_addr_o), 64'h0);
        chk("wrap_dat1", 64'(wb_dat_o), 64'h0);
        tick();
        wb_ack_i = 1'b0;
        chk("wrap_done", 64'({done, wb_cyc_o}), 64'b10);
        tick();

        // ---------------- asynchronous reset mid-burst ----------------
        issue(1'b1, 26'h40, 8'd7, 32'h1);
        tick();
        chk("mid_stb_high", 64'({wb_cyc_o, wb_stb_o, busy}), 64'b111);
        #2;
        sys_resetn = 1'b0;
        #1;
        chk("arst_cyc_stb_busy", 64'({wb_cyc_o, wb_stb_o, busy}), 64'd0);
        chk("arst_addr_dat", 64'({wb_addr_o, wb_dat_o}), 64'd0);
        @(negedge sys_clk);
        sys_resetn = 1'b1;
        tick();
        chk("arst_release_ready", 64'({cmd_ready, busy, done}), 64'b100);
        chk("arst_release_cyc", 64'(wb_cyc_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/wb_traffic_master.md
Name: wb_traffic_master

Overview:
- Synthesizable Wishbone master traffic generator and read-data checker for the SDRAM controller environment.
- Drives the controller's Wishbone slave port, the opposite end from the controller.
- Accepts burst commands on a valid/ready port and issues classic Wishbone write or read bursts carrying a deterministic data pattern.
- On reads, checks returned data against that pattern and reports error counts and status.

Parameters:
- dw, 32, Wishbone data width in bits (multiple of 8).
- app_addr_w, 26, Wishbone byte-address width.
- len_w, 8, burst length field width; burst beats = cmd_len+1.
- timeout_cyc, 255, maximum cycles a single beat waits for ack before abort (1..1023).

Ports:
- sys_clk  in  1  system/Wishbone clock; all logic on the rising edge.
- sys_resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_we  in  1  1=write burst, 0=read/check burst.
- cmd_addr  in  app_addr_w  start byte address (low log2(dw/8) bits ignored, forced 0).
- cmd_len  in  len_w  beats minus one.
- cmd_seed  in  dw  pattern seed.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write enable.
- wb_sel_o  out  dw/8  byte selects, all ones during stb.
- wb_addr_o  out  app_addr_w  byte address.
- wb_dat_o  out  dw  write data.
- wb_dat_i  in  dw  read data.
- wb_ack_i  in  1  beat acknowledge.
- wb_err_i  in  1  bus error.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at burst end (normal or aborted).
- err_cnt  out  16  read mismatches in last burst, saturates at 0xFFFF.
- first_err_addr  out  app_addr_w  address of first mismatch in last burst.
- timeout_flag  out  1  sticky; last burst aborted by timeout.
- bus_err_flag  out  1  sticky; last burst aborted by wb_err_i.

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_ready=1; wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, busy and done = 0; wb_addr_o and wb_dat_o = 0; err_cnt, first_err_addr, timeout_flag and bus_err_flag = 0.
- States: IDLE, BUS, DONE.
- IDLE:
  - cmd_ready=1.
  - On the accept edge: latch we, addr, len and seed; clear err_cnt, first_err_addr, timeout_flag and bus_err_flag; set beat index k=0; go to BUS.
- BUS:
  - cmd_ready=0; wb_cyc_o=wb_stb_o=1; wb_we_o=latched we; wb_sel_o all ones.
  - Beat k: wb_addr_o = start + k*(dw/8), modulo 2^app_addr_w (wraps silently).
  - Write data for beat k: wb_dat_o = seed + k (mod 2^dw).
  - Strobe is held continuously across beats; each ack completes one beat.
  - On an ack edge, address and data advance to beat k+1 at the same edge, so an ack every cycle gives one beat per cycle.
  - Read check: on ack with we=0, compare wb_dat_i against seed + k.
    - Mismatch: err_cnt increments (saturating).
    - First mismatch only: also capture the beat address into first_err_addr.
  - Last beat: ack at k==cmd_len drives cyc/stb/we/sel to 0 on that edge; go to DONE.
  - Timeout: a per-beat counter resets on every ack. If timeout_cyc cycles pass with no ack, drop cyc/stb, set timeout_flag and go to DONE.
  - Bus error: wb_err_i sampled high in BUS drops cyc/stb, sets bus_err_flag and goes to DONE. That beat is not counted or checked.
  - wb_err_i wins over wb_ack_i when both are high in the same cycle.
- DONE: done=1 for exactly one cycle; outputs idle; next state IDLE. cmd_ready stays 0 in DONE.
- Status outputs hold until the next command is accepted.
- Latency:
  - Accept at edge T gives cyc/stb high in cycle T+1.
  - An N-beat burst with zero-wait acks finishes its last ack at edge T+N.
  - done is high in cycle T+N+1.
  - cmd_ready returns in cycle T+N+2.
- Inputs wb_ack_i and wb_err_i are ignored outside BUS.
- Asserting reset mid-burst drops cyc/stb immediately (asynchronously) and returns all outputs to reset values.

Test Plan:
- Write, zero-wait: cmd_we=1, addr=0x100, len=3, seed=0xA5A50000, ack tied high → addresses 0x100/0x104/0x108/0x10C, data 0xA5A50000..0xA5A50003 on consecutive cycles; done one cycle after the 4th ack; cyc low with done.
- Read, clean data: read same burst, slave returns seed+k with one wait state per beat → err_cnt=0, flags 0, done after 8 bus cycles.
- Read, corrupted data: beats 1 and 2 corrupted → err_cnt=2, first_err_addr=0x104.
- Timeout: timeout_cyc=255, ack never asserted → cyc/stb drop after exactly 255 stb cycles; timeout_flag=1; done pulse.
- Bus error: wb_err_i asserted together with ack on beat 2 of len=7 → abort after 2 beats; bus_err_flag=1; err_cnt unaffected by beat 2.
- Wrap and reset: start addr 0x3FFFFFC, len=1 → second beat at address 0x0. Then assert sys_resetn low mid-burst → cyc/stb/busy 0 immediately, cmd_ready=1 after release.
